fan_sched: RTL and testbench

- Sequencing controller for an array of NUM_NODE fan_adder nodes that share one reduction job at a time.
- Accepts per-job node configurations (add_en, bypass_en, sel for each node) into a small FIFO.
- Applies the head configuration to the nodes and launches the input vector.
- Holds the configuration stable for the full pipelined floating-point adder latency of every tree level, then presents the result with a valid/ready handshake.

---
 rtl/fan_sched_if.sv | 34 +++
 rtl/fan_sched.sv | 150 +++++++++++++++
 tb/tb_fan_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fan_sched_if.sv
// Handshake and node-control bundle between the fan_sched controller and its environment.
interface fan_sched_if #(
    parameter int unsigned NUM_NODE = 8,
    parameter int unsigned SEL_IN   = 2
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [NUM_NODE-1:0]          cfg_add_en;
    logic [NUM_NODE-1:0]          cfg_bypass_en;
    logic [NUM_NODE*2*SEL_IN-1:0] cfg_sel;
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_NODE-1:0]          node_add_en;
    logic [NUM_NODE-1:0]          node_bypass_en;
    logic [NUM_NODE*2*SEL_IN-1:0] node_sel;
    logic                         launch;
    logic                         out_valid;
    logic                         out_ready;
    logic                         busy;
    logic [15:0]                  job_cnt;
    logic                         err_cfg;

    modport master (
        output cfg_valid, cfg_add_en, cfg_bypass_en, cfg_sel, in_valid, out_ready,
        input  cfg_ready, in_ready, node_add_en, node_bypass_en, node_sel, launch,
        input  out_valid, busy, job_cnt, err_cfg
    );

    modport slave (
        input  cfg_valid, cfg_add_en, cfg_bypass_en, cfg_sel, in_valid, out_ready,
        output cfg_ready, in_ready, node_add_en, node_bypass_en, node_sel, launch,
        output out_valid, busy, job_cnt, err_cfg
    );
endinterface

// File: rtl/fan_sched.sv
// Sequences one reduction job at a time through an array of fan_adder nodes:
// config FIFO -> apply config -> launch -> wait full adder-tree latency -> present result.
module fan_sched #(
    parameter int unsigned NUM_NODE   = 8,
    parameter int unsigned SEL_IN     = 2,
    parameter int unsigned ADD_LAT    = 11,
    parameter int unsigned LEVELS     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    fan_sched_if.slave bus
);
    localparam int unsigned SEL_W   = NUM_NODE * 2 * SEL_IN;
    localparam int unsigned CFG_W   = 2 * NUM_NODE + SEL_W;
    localparam int unsigned JOB_CYC = LEVELS * ADD_LAT;
    localparam int unsigned CNT_W   = $clog2(JOB_CYC + 1);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StArm, StWait, StDone} state_t;

    state_t              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [CFG_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]      r_fill;
    logic [NUM_NODE-1:0] r_add_en, r_bypass_en;
    logic [SEL_W-1:0]    r_sel;
    logic [15:0]         r_job_cnt;
    logic                r_err;

    logic                w_full, w_empty, w_push, w_pop, w_clr;
    logic                w_launch, w_in_ready, w_out_valid, w_job_inc;
    logic [NUM_NODE-1:0] w_conflict;
    logic [CFG_W-1:0]    w_cfg_in, w_head;

    assign w_full     = (r_fill == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty    = (r_fill == '0);
    assign w_push     = bus.cfg_valid & ~w_full;
    // Nodes asking for both add and bypass are neutralised rather than passed on.
    assign w_conflict = bus.cfg_add_en & bus.cfg_bypass_en;
    assign w_cfg_in   = {bus.cfg_sel, bus.cfg_bypass_en & ~w_conflict,
                         bus.cfg_add_en & ~w_conflict};
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cfg_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - 1'b1;
            end
            if (w_push && (|w_conflict)) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_pop       = 1'b0;
        w_clr       = 1'b0;
        w_launch    = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_job_inc   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StArm;
                end
            end
            StArm: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_launch  = 1'b1;
                    w_cnt_d   = CNT_W'(JOB_CYC - 1);
                    w_state_d = StWait;
                end
            end
            StWait: begin
                // Leaving when the count reaches 0 puts out_valid exactly JOB_CYC after launch.
                if (r_cnt != '0) w_cnt_d = r_cnt - 1'b1;
                if (r_cnt <= CNT_W'(1)) w_state_d = StDone;
            end
            StDone: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_job_inc = 1'b1;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StArm;
                    end else begin
                        w_clr     = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_add_en    <= '0;
            r_bypass_en <= '0;
            r_sel       <= '0;
            r_job_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_pop) begin
                r_add_en    <= w_head[NUM_NODE-1:0];
                r_bypass_en <= w_head[2*NUM_NODE-1:NUM_NODE];
                r_sel       <= w_head[CFG_W-1:2*NUM_NODE];
            end else if (w_clr) begin
                r_add_en    <= '0;
                r_bypass_en <= '0;
                r_sel       <= '0;
            end
            if (w_job_inc) r_job_cnt <= r_job_cnt + 16'd1;
        end
    end

    assign bus.cfg_ready      = ~w_full;
    assign bus.in_ready       = w_in_ready;
    assign bus.launch         = w_launch;
    assign bus.out_valid      = w_out_valid;
    assign bus.node_add_en    = r_add_en;
    assign bus.node_bypass_en = r_bypass_en;
    assign bus.node_sel       = r_sel;
    assign bus.busy           = (r_state != StIdle);
    assign bus.job_cnt        = r_job_cnt;
    assign bus.err_cfg        = r_err;
endmodule

// File: tb/tb_fan_sched.sv
// Directed self-checking bench for fan_sched: latency, FIFO fill/order, backpressure,
// config sanitising, asynchronous reset mid-job and job counter wrap.
module tb_fan_sched;
    localparam int unsigned NUM_NODE = 8;
    localparam int unsigned SEL_IN   = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fan_sched_if #(.NUM_NODE(NUM_NODE), .SEL_IN(SEL_IN)) bus ();

    fan_sched #(
        .NUM_NODE  (NUM_NODE),
        .SEL_IN    (SEL_IN),
        .ADD_LAT   (11),
        .LEVELS    (3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cfg(input logic [7:0] add, input logic [7:0] byp, input logic [31:0] sel);
        bus.cfg_valid     = 1'b1;
        bus.cfg_add_en    = add;
        bus.cfg_bypass_en = byp;
        bus.cfg_sel       = sel;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    // Waits for ARM, launches, measures latency, optionally stalls DONE, then handshakes.
    task automatic run_job(input logic [7:0] add, input logic [7:0] byp, input logic [31:0] sel,
                           input int hold);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("arm_reached", 64'(bus.in_ready), 64'd1);
        check_eq("arm_add_en", 64'(bus.node_add_en), 64'(add));
        check_eq("arm_bypass_en", 64'(bus.node_bypass_en), 64'(byp));
        check_eq("arm_sel", 64'(bus.node_sel), 64'(sel));
        bus.in_valid = 1'b1;
        #1;
        check_eq("launch", 64'(bus.launch), 64'd1);
        @(negedge clk);
        n = 1;
        // A stray in_valid during WAIT must not relaunch.
        #1;
        check_eq("wait_no_launch", 64'(bus.launch), 64'd0);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("latency", 64'(n), 64'd33);
        check_eq("done_add_en", 64'(bus.node_add_en), 64'(add));
        check_eq("done_sel", 64'(bus.node_sel), 64'(sel));
        check_eq("done_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("hold_sel", 64'(bus.node_sel), 64'(sel));
            check_eq("hold_busy", 64'(bus.busy), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sel_v;
        rst               = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.cfg_add_en    = '0;
        bus.cfg_bypass_en = '0;
        bus.cfg_sel       = '0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_node_sel", 64'(bus.node_sel), 64'd0);
        check_eq("rst_job_cnt", 64'(bus.job_cnt), 64'd0);
        check_eq("rst_err", 64'(bus.err_cfg), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single job, node0 add with sel 0110.
        push_cfg(8'h01, 8'h00, 32'h0000_0006);
        run_job(8'h01, 8'h00, 32'h0000_0006, 0);
        check_eq("j1_job_cnt", 64'(bus.job_cnt), 64'd1);
        check_eq("j1_idle_busy", 64'(bus.busy), 64'd0);
        check_eq("j1_idle_add_en", 64'(bus.node_add_en), 64'd0);
        check_eq("j1_idle_sel", 64'(bus.node_sel), 64'd0);

        // Five back-to-back pushes: one lands in ARM, four fill the FIFO.
        for (int i = 0; i < 5; i++) begin
            sel_v             = 32'h1111_1111 * 32'(i + 1);
            bus.cfg_valid     = 1'b1;
            bus.cfg_add_en    = 8'(1 << i);
            bus.cfg_bypass_en = 8'h00;
            bus.cfg_sel       = sel_v;
            #1;
            check_eq("burst_ready", 64'(bus.cfg_ready), 64'd1);
            @(negedge clk);
        end
        bus.cfg_add_en = 8'hFF;
        bus.cfg_sel    = 32'hDEAD_BEEF;
        #1;
        check_eq("full_ready", 64'(bus.cfg_ready), 64'd0);
        @(negedge clk);
        check_eq("full_ready2", 64'(bus.cfg_ready), 64'd0);
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel_v = 32'h1111_1111 * 32'(i + 1);
            run_job(8'(1 << i), 8'h00, sel_v, 0);
        end
        @(negedge clk);
        check_eq("burst_drained", 64'(bus.busy), 64'd0);
        check_eq("burst_job_cnt", 64'(bus.job_cnt), 64'd6);

        // Backpressure in DONE with the next config queued.
        push_cfg(8'h20, 8'h40, 32'hA5A5_0000);
        push_cfg(8'h80, 8'h01, 32'h0000_5A5A);
        run_job(8'h20, 8'h40, 32'hA5A5_0000, 10);
        check_eq("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("b2b_busy", 64'(bus.busy), 64'd1);
        check_eq("b2b_sel", 64'(bus.node_sel), 64'h5A5A);
        run_job(8'h80, 8'h01, 32'h0000_5A5A, 0);
        check_eq("b2b_job_cnt", 64'(bus.job_cnt), 64'd8);

        // Node3 add+bypass conflict is stripped and latches err_cfg.
        check_eq("err_before", 64'(bus.err_cfg), 64'd0);
        push_cfg(8'h09, 8'h08, 32'h0000_1000);
        check_eq("err_set", 64'(bus.err_cfg), 64'd1);
        run_job(8'h01, 8'h00, 32'h0000_1000, 0);
        push_cfg(8'h02, 8'h04, 32'h0000_0300);
        run_job(8'h02, 8'h04, 32'h0000_0300, 0);
        check_eq("err_sticky", 64'(bus.err_cfg), 64'd1);
        check_eq("err_job_cnt", 64'(bus.job_cnt), 64'd10);

        // Asynchronous reset in the middle of WAIT with a config still queued.
        push_cfg(8'h11, 8'h00, 32'h0000_0077);
        push_cfg(8'h22, 8'h00, 32'h0000_0088);
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("pre_rst_busy", 64'(bus.busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_node_add", 64'(bus.node_add_en), 64'd0);
        check_eq("arst_node_sel", 64'(bus.node_sel), 64'd0);
        check_eq("arst_busy", 64'(bus.busy), 64'd0);
        check_eq("arst_job_cnt", 64'(bus.job_cnt), 64'd0);
        check_eq("arst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check_eq("arst_err", 64'(bus.err_cfg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("arst_fifo_empty", 64'(bus.busy), 64'd0);

        // Job counter wrap.
        force dut.r_job_cnt = 16'hFFFF;
        #1;
        release dut.r_job_cnt;
        #1;
        check_eq("wrap_preload", 64'(bus.job_cnt), 64'hFFFF);
        @(negedge clk);
        push_cfg(8'h04, 8'h00, 32'h0000_0040);
        run_job(8'h04, 8'h00, 32'h0000_0040, 0);
        check_eq("wrap_job_cnt", 64'(bus.job_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
